// File: rtl/mode_stepper_if.sv
// Front-panel mode selector bundle: raw active-low buttons in, mode index, change pulse and sample tick out.
interface mode_stepper_if #(
  parameter int SEL_W = 2
);
  logic             next_n;
  logic             prev_n;
  logic [SEL_W-1:0] sel;
  logic             changed;
  logic             tick;

  modport master (output next_n, output prev_n, input sel, input changed, input tick);
  modport slave  (input next_n, input prev_n, output sel, output changed, output tick);
endinterface

// File: rtl/mode_stepper.sv
// Debounced next/prev pushbuttons stepping a wrap-around mode index, with hold-to-auto-repeat.
// Steps land on the tick edge that completes a stable history; no backpressure, free-running.
module mode_stepper #(
  parameter int TICK_DIV     = 100000,
  parameter int DB_SAMPLES   = 4,
  parameter int NUM_MODES    = 4,
  parameter int RESET_MODE   = 0,
  parameter int REPEAT_TICKS = 50
) (
  input  logic          clk,
  input  logic          reset,
  mode_stepper_if.slave bus
);
  localparam int SEL_W    = ($clog2(NUM_MODES) > 1) ? $clog2(NUM_MODES) : 1;
  localparam int CNT_W    = $clog2(TICK_DIV);
  localparam int RPT_W    = (REPEAT_TICKS > 2) ? $clog2(REPEAT_TICKS) : 1;
  localparam int RPT_LAST = (REPEAT_TICKS > 0) ? REPEAT_TICKS - 1 : 0;

  logic [CNT_W-1:0]      cnt_q;
  logic                  tick;
  logic [1:0]            sync1_q, sync2_q, pressed;
  logic [DB_SAMPLES-2:0] hist_q [2];
  logic [DB_SAMPLES-1:0] hist_nx [2];
  logic [1:0]            db_q, db_nx;
  logic [RPT_W-1:0]      rpt_q [2];
  logic [RPT_W-1:0]      rpt_nx [2];
  logic                  lock_q, lock_nx;
  logic [1:0]            fire;
  logic [SEL_W-1:0]      sel_q;
  logic                  changed_q;

  assign tick    = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign pressed = ~sync2_q;   // bit 0 = next, bit 1 = prev

  always_comb begin
    fire    = 2'b00;
    lock_nx = lock_q;
    db_nx   = db_q;
    for (int b = 0; b < 2; b++) begin
      // Only the newest DB_SAMPLES-1 samples are kept; the current one completes the window.
      hist_nx[b] = {hist_q[b], pressed[b]};
      rpt_nx[b]  = rpt_q[b];
      if (&hist_nx[b])       db_nx[b] = 1'b1;
      else if (~|hist_nx[b]) db_nx[b] = 1'b0;
    end
    if (tick) begin
      if (&db_nx) begin
        lock_nx   = 1'b1;
        rpt_nx[0] = '0;
        rpt_nx[1] = '0;
      end else begin
        // A two-button chord stays locked out until both have been released.
        if (~|db_nx) lock_nx = 1'b0;
        for (int b = 0; b < 2; b++) begin
          if (!db_nx[b] || lock_nx) begin
            rpt_nx[b] = '0;
          end else if (!db_q[b]) begin
            fire[b]   = 1'b1;
            rpt_nx[b] = '0;
          end else if (REPEAT_TICKS > 0) begin
            if (rpt_q[b] == RPT_W'(RPT_LAST)) begin
              fire[b]   = 1'b1;
              rpt_nx[b] = '0;
            end else begin
              rpt_nx[b] = rpt_q[b] + RPT_W'(1);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      sync1_q   <= 2'b11;
      sync2_q   <= 2'b11;
      db_q      <= 2'b00;
      lock_q    <= 1'b0;
      sel_q     <= SEL_W'(RESET_MODE);
      changed_q <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        hist_q[b] <= '0;
        rpt_q[b]  <= '0;
      end
    end else begin
      cnt_q     <= tick ? '0 : cnt_q + CNT_W'(1);
      sync1_q   <= {bus.prev_n, bus.next_n};
      sync2_q   <= sync1_q;
      lock_q    <= lock_nx;
      changed_q <= |fire;
      for (int b = 0; b < 2; b++) begin
        rpt_q[b] <= rpt_nx[b];
        if (tick) hist_q[b] <= hist_nx[b][DB_SAMPLES-2:0];
      end
      if (tick) db_q <= db_nx;
      if (fire[0]) begin
        sel_q <= (sel_q == SEL_W'(NUM_MODES - 1)) ? '0 : sel_q + SEL_W'(1);
      end else if (fire[1]) begin
        sel_q <= (sel_q == '0) ? SEL_W'(NUM_MODES - 1) : sel_q - SEL_W'(1);
      end
    end
  end

  assign bus.sel     = sel_q;
  assign bus.changed = changed_q;
  assign bus.tick    = tick;
endmodule

// File: tb/tb_mode_stepper.sv
// Randomised bench for mode_stepper: a tick-level behavioural model feeds an expected-index queue drained by a monitor.
module tb_mode_stepper;
  localparam int TICK_DIV     = 4;
  localparam int DB_SAMPLES   = 3;
  localparam int NUM_MODES    = 3;
  localparam int RESET_MODE   = 1;
  localparam int REPEAT_TICKS = 2;
  localparam int SEL_W        = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   exp_q[$];

  mode_stepper_if #(.SEL_W(SEL_W)) bus ();

  mode_stepper #(
    .TICK_DIV(TICK_DIV), .DB_SAMPLES(DB_SAMPLES), .NUM_MODES(NUM_MODES),
    .RESET_MODE(RESET_MODE), .REPEAT_TICKS(REPEAT_TICKS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #50 clk = ~clk;

  // Behavioural model: button levels seen two edges late, debounced over the last DB_SAMPLES tick samples.
  int         m_phase = 0;
  int         m_sel = RESET_MODE;
  int         tick_idx = 0;
  int         last_step[2];
  int         ones[2];
  bit         blocked = 1'b0;
  logic [1:0] m_db = 2'b00;
  logic [1:0] new_db;
  logic [1:0] smp;
  logic [1:0] lvl_q[$];
  logic [1:0] samp_q[$];

  task automatic do_step(input int b);
    if (b == 0) m_sel = (m_sel + 1) % NUM_MODES;
    else        m_sel = (m_sel + NUM_MODES - 1) % NUM_MODES;
    exp_q.push_back(m_sel);
    last_step[b] = tick_idx;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_phase  = 0;
      m_sel    = RESET_MODE;
      m_db     = 2'b00;
      blocked  = 1'b0;
      tick_idx = 0;
      lvl_q    = '{2'b00, 2'b00};
      samp_q   = {};
      for (int i = 0; i < DB_SAMPLES; i++) samp_q.push_back(2'b00);
    end else begin
      smp = lvl_q.pop_front();
      lvl_q.push_back({~bus.prev_n, ~bus.next_n});
      if (m_phase == TICK_DIV - 1) begin
        tick_idx++;
        void'(samp_q.pop_front());
        samp_q.push_back(smp);
        new_db = m_db;
        for (int b = 0; b < 2; b++) begin
          ones[b] = 0;
          foreach (samp_q[i]) ones[b] += int'(samp_q[i][b]);
          if (ones[b] == DB_SAMPLES) new_db[b] = 1'b1;
          else if (ones[b] == 0)     new_db[b] = 1'b0;
        end
        if (new_db == 2'b11)      blocked = 1'b1;
        else if (new_db == 2'b00) blocked = 1'b0;
        if (!blocked) begin
          for (int b = 0; b < 2; b++) begin
            if (new_db[b] && !m_db[b]) do_step(b);
            else if (new_db[b] && REPEAT_TICKS > 0 && tick_idx - last_step[b] == REPEAT_TICKS) do_step(b);
          end
        end
        m_db = new_db;
      end
      m_phase = (m_phase + 1) % TICK_DIV;
    end
  end

  // Monitor: drains the expected queue on every changed pulse and tracks tick and sel each cycle.
  int exp_sel;
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (bus.tick !== (m_phase == TICK_DIV - 1)) begin
        errors++;
        $display("FAIL tick @%0t: got %b expected %b", $time, bus.tick, (m_phase == TICK_DIV - 1));
      end
      if (bus.changed === 1'b1 || exp_q.size() != 0) begin
        checks++;
        if (bus.changed !== 1'b1) begin
          errors++;
          $display("FAIL changed_missing @%0t: got changed=%b expected 1", $time, bus.changed);
          void'(exp_q.pop_front());
        end else if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL changed_spurious @%0t: got changed=1 expected 0", $time);
        end else begin
          exp_sel = exp_q.pop_front();
          if (int'(bus.sel) != exp_sel) begin
            errors++;
            $display("FAIL step_sel @%0t: got %0d expected %0d", $time, bus.sel, exp_sel);
          end
        end
      end
      checks++;
      if (int'(bus.sel) != m_sel) begin
        errors++;
        $display("FAIL sel_track @%0t: got %0d expected %0d", $time, bus.sel, m_sel);
      end
    end
  end

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic hold(input bit nx_n, input bit pv_n, input int n);
    bus.next_n = nx_n;
    bus.prev_n = pv_n;
    repeat (n) @(negedge clk);
  endtask

  logic [1:0] lvl;
  initial begin
    bus.next_n = 1'b1;
    bus.prev_n = 1'b1;
    reset      = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset_sel", int'(bus.sel), RESET_MODE);
    check_val("reset_changed", int'(bus.changed), 0);
    check_val("reset_tick", int'(bus.tick), 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    hold(1, 1, 40);
    check_val("idle_sel", int'(bus.sel), RESET_MODE);
    // Single presses forward and back, including the wrap points.
    hold(0, 1, 12); hold(1, 1, 24);
    hold(1, 0, 12); hold(1, 1, 24);
    hold(1, 0, 12); hold(1, 1, 24);
    hold(1, 0, 12); hold(1, 1, 24);
    hold(0, 1, 12); hold(1, 1, 24);
    // Contact bounce shorter than a tick period, then a clean hold.
    for (int i = 0; i < 10; i++) hold(i[0], 1, 3);
    hold(1, 1, 24);
    hold(0, 1, 16); hold(1, 1, 24);
    // Long hold for auto-repeat.
    hold(0, 1, 48); hold(1, 1, 24);
    // Chords: simultaneous press, then next added while prev is held.
    hold(0, 0, 24); hold(1, 1, 24);
    hold(1, 0, 8);  hold(0, 0, 24); hold(0, 1, 16); hold(1, 1, 24);
    // Reset pulse while next is held.
    hold(0, 1, 16);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("reset_mid_press_sel", int'(bus.sel), RESET_MODE);
    hold(0, 1, 20); hold(1, 1, 24);

    for (int seg = 0; seg < 150; seg++) begin
      lvl = 2'($urandom_range(0, 3));
      hold(~lvl[0], ~lvl[1], $urandom_range(1, 40));
    end
    hold(1, 1, 40);
    check_val("queue_drained", exp_q.size(), 0);
    check_val("final_sel", int'(bus.sel), m_sel);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mode_stepper.md
# mode_stepper

Parametrised front-panel mode selector. It turns two raw active-low pushbuttons (next/prev) into a debounced, wrap-around mode index with optional hold-to-auto-repeat. It runs entirely in the system clock domain and uses a one-cycle `tick` enable in place of a derived slow clock. It feeds the mode index to the display and datapath mux logic of the top level.

## Interface
- `TICK_DIV`, 100000, system clocks per sample tick (≥2); 10 ms at 10 MHz
- `DB_SAMPLES`, 4, consecutive agreeing tick samples needed to change debounced state (≥2)
- `NUM_MODES`, 4, number of modes (≥2); index range 0..NUM_MODES-1
- `RESET_MODE`, 0, mode index after reset (<NUM_MODES)
- `REPEAT_TICKS`, 50, ticks between auto-repeat steps while held; 0 disables auto-repeat
- Derived localparam `SEL_W` = max(1, $clog2(NUM_MODES))
- `clk` in 1: system clock; all logic on rising edge
- `reset` in 1: synchronous, active-high
- `next_n` in 1: raw asynchronous button, active-low, step forward
- `prev_n` in 1: raw asynchronous button, active-low, step backward
- `sel` out SEL_W: current mode index, registered
- `changed` out 1: one-cycle pulse, high in the first cycle `sel` shows a new value
- `tick` out 1: one-cycle sample-enable pulse, high once every TICK_DIV cycles

## Operation
- Tick generator: counter 0..TICK_DIV-1, wraps to 0. `tick` is high while count == TICK_DIV-1.
- Synchroniser: two flops per button. Inverted to active-high `pressed` after synchronisation.
- Debounce, per button: DB_SAMPLES-bit history shifts in `pressed` only on tick cycles.
  - If the shifted-in history is all ones, debounced state becomes 1.
  - If it is all zeros, debounced state becomes 0.
  - Otherwise the debounced state holds.
- Step events are evaluated on tick edges only:
  - Debounced 0→1 transition of exactly one button → one step in that direction.
  - Auto-repeat, REPEAT_TICKS>0: while exactly one button's debounced state is 1, a per-button repeat counter increments each tick. When it reaches REPEAT_TICKS it issues a step and reloads 0. The counter is 0 on the press step and is cleared whenever that button is released.
- Both debounced states 1, or both rising on the same tick:
  - No step is issued.
  - Both repeat counters are held at 0.
  - Stepping resumes only on a fresh rise after release.
- Step arithmetic:
  - next: sel == NUM_MODES-1 → 0, else sel+1.
  - prev: sel == 0 → NUM_MODES-1, else sel−1.
  - Non-power-of-two NUM_MODES never produces an index ≥ NUM_MODES.
- `changed` is registered with `sel`. It is 1 for exactly the cycle after a step edge, and 0 otherwise. At most one step per tick.
- Reset values, all synchronous:
  - `sel` = RESET_MODE; `changed` = 0; `tick` = 0; tick counter = 0.
  - Synchroniser flops = 1 (released); histories = 0; debounced states = 0; repeat counters = 0.
- Reset asserted mid-press: all state is cleared. A button still held after reset must be re-debounced (DB_SAMPLES ticks) and then counts as a new press.

## Timing
- First `tick` high in cycle TICK_DIV-1 after reset deasserts (count 0 in the first post-reset cycle). Thereafter the period is exactly TICK_DIV.
- Press latency: 2 cycles of synchronisation, then DB_SAMPLES tick samples of stable level. `sel` updates at the tick edge that completes the all-ones history. Worst case ≈ (DB_SAMPLES+1)·TICK_DIV + 2 cycles.
- Release is debounced identically. A glitch shorter than one tick period never changes `sel`.
- Auto-repeat step k≥1 occurs k·REPEAT_TICKS ticks after the press step.
- No combinational path from inputs to outputs.

## Test plan
Bench parameters: TICK_DIV=4, DB_SAMPLES=3, NUM_MODES=3, RESET_MODE=1, REPEAT_TICKS=2.

- Reset, then idle for 40 cycles → `sel`=1, `changed`=0 throughout; `tick` high at cycles 3, 7, 11, …
- Assert next_n=0 and hold for 3 ticks, then release → `sel` 1→2 with a single `changed` pulse; no further change after release; prev ×2 from 2 then gives 1, then 0.
- Wrap-around: next from `sel`=2 → 0; prev from 0 → 2.
- Bounce: toggle next_n every 3 cycles for 30 cycles → `sel` unchanged and `changed` never high; then a stable hold → exactly one step.
- Hold next_n low for 12 ticks → press step, then steps every 2 ticks; starting at 1 the sequence is 2, 0, 1, 2, 0, … with one `changed` pulse per step.
- Press both buttons together, then hold next while prev is held → no steps. Also: `reset` pulse during a held next → `sel`=1 immediately, then one step 3 ticks later if still held.
